instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_set_pkg.sv | 19 +
 rtl/ifetch_line_buffer.sv | 44 ++++
 rtl/instruction_fetch.sv | 129 ++++++++++++
 tb/tb_instruction_fetch.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_set_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instruction_set;

    // One instruction is five bytes: {opcode, dest, src}.
    localparam int INSTR_BYTES = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } ifetch_state_t;

    // Byte address of instruction index pc; wraps at 2^16.
    function automatic logic [15:0] instr_base(input logic [15:0] pc);
        return pc * 16'd5;
    endfunction

endpackage

// File: rtl/ifetch_line_buffer.sv
// One-entry buffer remembering the last completed fetch (index + instruction).
// Only instantiated when IFETCH_LINE_BUFFER_EN is defined.
module ifetch_line_buffer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] start_pc,
    input  logic        fill,
    input  logic [39:0] fill_instr,
    input  logic        invalidate,
    input  logic [15:0] lookup_pc,
    output logic        hit,
    output logic [39:0] hit_instr
);

    logic [15:0] pend_pc;
    logic [15:0] entry_pc;
    logic [39:0] entry_instr;
    logic        entry_valid;

    // Remember the index of the fetch in flight, commit it when the fetch completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_pc     <= '0;
            entry_pc    <= '0;
            entry_instr <= '0;
            entry_valid <= 1'b0;
        end else begin
            if (start)
                pend_pc <= start_pc;
            if (invalidate) begin
                entry_valid <= 1'b0;
            end else if (fill) begin
                entry_valid <= 1'b1;
                entry_pc    <= pend_pc;
                entry_instr <= fill_instr;
            end
        end
    end

    assign hit       = entry_valid && (entry_pc == lookup_pc);
    assign hit_instr = entry_instr;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: assembles a 5-byte instruction from a byte-wide memory,
// with per-beat timeout, flush and an optional one-entry line buffer
// (enable with macro IFETCH_LINE_BUFFER_EN).
module instruction_fetch
    import instruction_set::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_req,
    input  logic [15:0] fetch_pc,
    input  logic        flush,
    input  logic        instr_consume,
    input  logic [7:0]  mem_rd_data,
    input  logic        mem_rd_ack,
    output logic        mem_rd_req,
    output logic [15:0] mem_addr,
    output logic [39:0] instruction,
    output logic        instr_valid,
    output logic        fetch_busy,
    output logic        fetch_fault
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    ifetch_state_t     state, state_next;
    logic [15:0]       base;
    logic [2:0]        beat;
    logic [WAIT_W-1:0] wait_cnt;
    logic [39:0]       instr_q;

    logic              accept;
    logic              capture;
    logic              last_beat;
    logic              timeout;
    logic              hit;
    logic [39:0]       hit_instr;

    // Next-state logic; flush always wins and returns to IDLE.
    always_comb begin
        state_next = state;
        accept     = fetch_req && !flush &&
                     (state == IDLE || state == FAULT || (state == HOLD && instr_consume));
        capture    = (state == READ) && mem_rd_ack && !flush;
        last_beat  = (beat == 3'(INSTR_BYTES - 1));
        timeout    = (state == READ) && !mem_rd_ack && !flush &&
                     (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
        case (state)
            IDLE, FAULT: begin
                if (accept)
                    state_next = hit ? HOLD : READ;
            end
            READ: begin
                if (capture && last_beat)
                    state_next = HOLD;
                else if (timeout)
                    state_next = FAULT;
            end
            HOLD: begin
                if (accept)
                    state_next = hit ? HOLD : READ;
                else if (instr_consume)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush)
            state_next = IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Beat/wait counters and instruction assembly; reset discards any partial fetch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base     <= '0;
            beat     <= '0;
            wait_cnt <= '0;
            instr_q  <= '0;
        end else if (accept) begin
            base     <= instr_base(fetch_pc);
            beat     <= '0;
            wait_cnt <= '0;
            if (hit)
                instr_q <= hit_instr;
        end else if (capture) begin
            for (int i = 0; i < INSTR_BYTES; i++)
                if (beat == 3'(i))
                    instr_q[(INSTR_BYTES - 1 - i) * 8 +: 8] <= mem_rd_data;
            beat     <= beat + 3'd1;
            wait_cnt <= '0;
        end else if (state == READ) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

`ifdef IFETCH_LINE_BUFFER_EN
    ifetch_line_buffer u_line_buffer (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (accept),
        .start_pc   (fetch_pc),
        .fill       (capture && last_beat),
        .fill_instr ({instr_q[39:8], mem_rd_data}),
        .invalidate (flush || timeout),
        .lookup_pc  (fetch_pc),
        .hit        (hit),
        .hit_instr  (hit_instr)
    );
`else
    assign hit       = 1'b0;
    assign hit_instr = '0;
`endif

    assign mem_rd_req  = (state == READ);
    assign mem_addr    = (state == READ) ? base + 16'(beat) : 16'h0000;
    assign instruction = instr_q;
    assign instr_valid = (state == HOLD);
    assign fetch_busy  = (state == READ);
    assign fetch_fault = (state == FAULT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: byte memory model with a
// scoreboard of expected beat addresses and expected instructions.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        fetch_req = 1'b0;
    logic [15:0] fetch_pc = 16'h0000;
    logic        flush = 1'b0;
    logic        instr_consume = 1'b0;
    logic [7:0]  mem_rd_data;
    logic        mem_rd_ack;
    logic        mem_rd_req;
    logic [15:0] mem_addr;
    logic [39:0] instruction;
    logic        instr_valid;
    logic        fetch_busy;
    logic        fetch_fault;

    logic        ack_en = 1'b1;
    logic [7:0]  mem [0:65535];
    logic [15:0] exp_addr [$];
    logic [39:0] exp_instr [$];
    int          n_checks = 0;
    int          n_errors = 0;

    // Zero-wait memory; ack_en=0 models a memory that never answers.
    assign mem_rd_ack  = mem_rd_req & ack_en;
    assign mem_rd_data = mem_rd_ack ? mem[mem_addr] : 8'h00;

    always #5 clk = ~clk;

    instruction_fetch #(.TIMEOUT_CYCLES(64)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .fetch_req     (fetch_req),
        .fetch_pc      (fetch_pc),
        .flush         (flush),
        .instr_consume (instr_consume),
        .mem_rd_data   (mem_rd_data),
        .mem_rd_ack    (mem_rd_ack),
        .mem_rd_req    (mem_rd_req),
        .mem_addr      (mem_addr),
        .instruction   (instruction),
        .instr_valid   (instr_valid),
        .fetch_busy    (fetch_busy),
        .fetch_fault   (fetch_fault)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Push the 5 expected beat addresses starting at b and the instruction they assemble.
    task automatic push_fetch(input logic [15:0] b);
        logic [15:0] a;
        logic [39:0] e;
        e = '0;
        for (int i = 0; i < 5; i++) begin
            a = b + 16'(i);
            exp_addr.push_back(a);
            e = {e[31:0], mem[a]};
        end
        exp_instr.push_back(e);
    endtask

    // Advance one clock; sample #1 later and retire any memory beat against the scoreboard.
    task automatic step();
        logic [15:0] ea;
        @(posedge clk);
        #1;
        if (mem_rd_req && mem_rd_ack) begin
            n_checks++;
            if (exp_addr.size() == 0) begin
                n_errors++;
                $display("FAIL beat_addr: unexpected beat at addr %h, expected none", mem_addr);
            end else begin
                ea = exp_addr.pop_front();
                if (mem_addr !== ea) begin
                    n_errors++;
                    $display("FAIL beat_addr: got %h expected %h", mem_addr, ea);
                end
            end
        end
    endtask

    // Step until instr_valid; cyc counts edges since the request was driven, -1 if bound expired.
    task automatic wait_valid(input int max, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
            fetch_req     = 1'b0;
            instr_consume = 1'b0;
        end while (!instr_valid && cyc < max);
        if (!instr_valid)
            cyc = -1;
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({mem_rd_req, mem_addr, instruction, instr_valid, fetch_busy, fetch_fault} !== 60'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: got req=%b addr=%h instr=%h v=%b busy=%b fault=%b, expected all 0",
                     mem_rd_req, mem_addr, instruction, instr_valid, fetch_busy, fetch_fault);
        end
        fetch_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({mem_rd_req, fetch_busy, instr_valid} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_hold: req=%b busy=%b v=%b while reset held, expected 000",
                     mem_rd_req, fetch_busy, instr_valid);
        end
        fetch_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_zero_wait();
        int cyc;
        logic [39:0] e;
        for (int i = 0; i < 5; i++) exp_addr.push_back(16'd10 + 16'(i));
        exp_instr.push_back(40'h0400010005);
        fetch_pc  = 16'h0002;
        fetch_req = 1'b1;
        wait_valid(20, cyc);
        n_checks++;
        if (cyc !== 6) begin
            n_errors++;
            $display("FAIL zero_wait_latency: got %0d cycles expected 6", cyc);
        end
        e = exp_instr.pop_front();
        n_checks++;
        if (instruction !== e) begin
            n_errors++;
            $display("FAIL zero_wait_instr: got %h expected %h", instruction, e);
        end
        n_checks++;
        if (mem_rd_req !== 1'b0 || fetch_busy !== 1'b0 || exp_addr.size() != 0) begin
            n_errors++;
            $display("FAIL zero_wait_done: req=%b busy=%b pending_beats=%0d expected 0 0 0",
                     mem_rd_req, fetch_busy, exp_addr.size());
        end
    endtask

    task automatic test_hold();
        // In HOLD without consume, fetch_req is ignored and outputs stay put.
        fetch_pc  = 16'h0040;
        fetch_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (instr_valid !== 1'b1 || fetch_busy !== 1'b0 || instruction !== 40'h0400010005) begin
                n_errors++;
                $display("FAIL hold_stable: v=%b busy=%b instr=%h expected 1 0 0400010005",
                         instr_valid, fetch_busy, instruction);
            end
        end
        fetch_req     = 1'b0;
        instr_consume = 1'b1;
        step();
        instr_consume = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0 || fetch_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_consume: v=%b busy=%b expected 0 0", instr_valid, fetch_busy);
        end
        // Consume outside HOLD does nothing.
        instr_consume = 1'b1;
        step();
        instr_consume = 1'b0;
        n_checks++;
        if ({instr_valid, fetch_busy, mem_rd_req} !== 3'b000) begin
            n_errors++;
            $display("FAIL consume_idle: v/busy/req=%b expected 000", {instr_valid, fetch_busy, mem_rd_req});
        end
    endtask

    task automatic test_wrap();
        int cyc;
        logic [39:0] e;
        exp_addr.push_back(16'hFFFF);
        for (int i = 0; i < 4; i++) exp_addr.push_back(16'(i));
        exp_instr.push_back(40'hA1B2C3D4E5);
        fetch_pc  = 16'h3333;
        fetch_req = 1'b1;
        wait_valid(20, cyc);
        e = exp_instr.pop_front();
        n_checks++;
        if (cyc !== 6 || instruction !== e) begin
            n_errors++;
            $display("FAIL wrap: got cyc=%0d instr=%h expected cyc=6 instr=%h", cyc, instruction, e);
        end
        instr_consume = 1'b1;
        step();
        instr_consume = 1'b0;
    endtask

    task automatic test_timeout();
        int cyc;
        logic [39:0] e;
        ack_en    = 1'b0;
        fetch_pc  = 16'h0007;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        n_checks++;
        if (fetch_busy !== 1'b1 || mem_addr !== 16'h0023) begin
            n_errors++;
            $display("FAIL timeout_start: busy=%b addr=%h expected 1 0023", fetch_busy, mem_addr);
        end
        repeat (63) step();
        n_checks++;
        if (fetch_fault !== 1'b0 || mem_rd_req !== 1'b1 || mem_addr !== 16'h0023) begin
            n_errors++;
            $display("FAIL timeout_early: fault=%b req=%b addr=%h expected 0 1 0023",
                     fetch_fault, mem_rd_req, mem_addr);
        end
        step();
        n_checks++;
        if ({fetch_fault, mem_rd_req, instr_valid, fetch_busy} !== 4'b1000) begin
            n_errors++;
            $display("FAIL timeout_fault: fault/req/v/busy=%b expected 1000",
                     {fetch_fault, mem_rd_req, instr_valid, fetch_busy});
        end
        ack_en = 1'b1;
        push_fetch(16'd10);
        fetch_pc  = 16'h0002;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        n_checks++;
        if (fetch_fault !== 1'b0 || fetch_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL fault_clear: fault=%b busy=%b expected 0 1", fetch_fault, fetch_busy);
        end
        wait_valid(20, cyc);
        e = exp_instr.pop_front();
        n_checks++;
        if (cyc !== 5 || instruction !== e) begin
            n_errors++;
            $display("FAIL after_fault_fetch: cyc=%0d instr=%h expected cyc=5 instr=%h", cyc, instruction, e);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [39:0] e;
        // Still in HOLD from the previous fetch.
        push_fetch(16'h0500);
        fetch_pc      = 16'h0100;
        fetch_req     = 1'b1;
        instr_consume = 1'b1;
        step();
        fetch_req     = 1'b0;
        instr_consume = 1'b0;
        n_checks++;
        if (fetch_busy !== 1'b1 || mem_addr !== 16'h0500 || instr_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_start: busy=%b addr=%h v=%b expected 1 0500 0", fetch_busy, mem_addr, instr_valid);
        end
        wait_valid(20, cyc);
        e = exp_instr.pop_front();
        n_checks++;
        if (cyc !== 5 || instruction !== e) begin
            n_errors++;
            $display("FAIL b2b_instr: cyc=%0d instr=%h expected cyc=5 instr=%h", cyc, instruction, e);
        end
        instr_consume = 1'b1;
        step();
        instr_consume = 1'b0;
    endtask

    task automatic test_flush();
        int seen;
        for (int i = 0; i < 3; i++) exp_addr.push_back(16'h0A00 + 16'(i));
        fetch_pc  = 16'h0200;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        step();
        step();
        // Beat 2 is being acked right now; flush lands with it.
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_checks++;
        if ({mem_rd_req, instr_valid, fetch_busy} !== 3'b000 || exp_addr.size() != 0) begin
            n_errors++;
            $display("FAIL flush_idle: req/v/busy=%b pending=%0d expected 000 0",
                     {mem_rd_req, instr_valid, fetch_busy}, exp_addr.size());
        end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (mem_rd_req) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_errors++;
            $display("FAIL flush_quiet: got %0d req cycles expected 0", seen);
        end
        // Flush beats a simultaneous request.
        fetch_pc  = 16'h0002;
        fetch_req = 1'b1;
        flush     = 1'b1;
        step();
        fetch_req = 1'b0;
        flush     = 1'b0;
        n_checks++;
        if ({mem_rd_req, instr_valid, fetch_busy} !== 3'b000) begin
            n_errors++;
            $display("FAIL flush_over_req: req/v/busy=%b expected 000", {mem_rd_req, instr_valid, fetch_busy});
        end
    endtask

    task automatic test_reset_mid_read();
        for (int i = 0; i < 2; i++) exp_addr.push_back(16'h0F00 + 16'(i));
        fetch_pc  = 16'h0300;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        step();
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (mem_rd_req !== 1'b0 || fetch_busy !== 1'b0 || instruction !== 40'h0) begin
            n_errors++;
            $display("FAIL reset_mid_read: req=%b busy=%b instr=%h expected 0 0 0",
                     mem_rd_req, fetch_busy, instruction);
        end
        exp_addr.delete();
        @(negedge clk);
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_repeat_fetch();
        int cyc;
        int exp_lat;
        logic [39:0] e;
        push_fetch(16'd10);
        fetch_pc  = 16'h0002;
        fetch_req = 1'b1;
        wait_valid(20, cyc);
        e = exp_instr.pop_front();
        n_checks++;
        if (cyc !== 6 || instruction !== e) begin
            n_errors++;
            $display("FAIL first_fetch: cyc=%0d instr=%h expected cyc=6 instr=%h", cyc, instruction, e);
        end
        instr_consume = 1'b1;
        step();
        instr_consume = 1'b0;
`ifdef IFETCH_LINE_BUFFER_EN
        exp_lat = 1;
        exp_instr.push_back(40'h0400010005);
`else
        exp_lat = 6;
        push_fetch(16'd10);
`endif
        fetch_pc  = 16'h0002;
        fetch_req = 1'b1;
        wait_valid(20, cyc);
        e = exp_instr.pop_front();
        n_checks++;
        if (cyc !== exp_lat || instruction !== e || mem_rd_req !== 1'b0 || exp_addr.size() != 0) begin
            n_errors++;
            $display("FAIL repeat_fetch: cyc=%0d instr=%h req=%b pending=%0d expected cyc=%0d instr=%h 0 0",
                     cyc, instruction, mem_rd_req, exp_addr.size(), exp_lat, e);
        end
        instr_consume = 1'b1;
        step();
        instr_consume = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
        mem[10] = 8'h04; mem[11] = 8'h00; mem[12] = 8'h01; mem[13] = 8'h00; mem[14] = 8'h05;
        mem[16'hFFFF] = 8'hA1; mem[0] = 8'hB2; mem[1] = 8'hC3; mem[2] = 8'hD4; mem[3] = 8'hE5;

        test_reset();
        test_zero_wait();
        test_hold();
        test_wrap();
        test_timeout();
        test_back_to_back();
        test_flush();
        test_reset_mid_read();
        test_repeat_fetch();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
